decode_len_sequencer: RTL and testbench

Byte-serial x86-64 instruction-boundary sequencer sitting between the fetch byte buffer and the decode stage. Consumes one instruction byte per handshake and walks prefixes, REX, opcode (one-byte map or 0x0F escape), ModRM, SIB, displacement and immediate. Consults the opcode ModRM-presence table (256-bit vector from the opcode table block) to decide the ModRM step. Emits one descriptor per instruction with its total length and key fields; only the one-byte map is fully sized.

---
 rtl/decode_len_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_decode_len_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_len_sequencer.sv
// Byte-serial x86-64 instruction boundary sequencer: walks prefix/REX/opcode/ModRM/SIB/disp/imm, emits one descriptor.
// Latency: descriptor valid the cycle after the last instruction byte is accepted; one byte per cycle otherwise.
// Backpressure: in_ready is low while a descriptor waits for out_ready; flush drops partial and pending work.
// Ports: clk/reset_n, flush, modrm_tbl (bit 255-op = ModRM present), in_valid/in_ready/in_byte, out_valid/out_ready, out_* fields.
module decode_len_sequencer #(
  parameter int unsigned MAX_LEN = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [255:0] modrm_tbl,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_len,
  output logic [7:0]   out_opcode,
  output logic         out_esc,
  output logic [3:0]   out_rex,
  output logic         out_opsize16,
  output logic         out_has_modrm,
  output logic [7:0]   out_modrm,
  output logic         out_err
);

  typedef enum logic [2:0] {PFX, ESC2, MODRM, SIB, DISP, IMM, DONE} state_t;

  state_t     state, state_n;
  logic [3:0] count, count_n;
  logic [3:0] rex, rex_n;
  logic       opsize16, opsize16_n;
  logic       esc, esc_n;
  logic [7:0] opcode, opcode_n;
  logic       has_modrm, has_modrm_n;
  logic [7:0] modrm, modrm_n;
  logic       err, err_n;
  logic [2:0] disp_left, disp_left_n;
  logic [3:0] imm_left, imm_left_n;
  logic       hm;
  logic [3:0] imm_sz;
  logic [2:0] disp_sz;
  logic       done;

  // Immediate byte count; reg_f only matters for the F6/F7 group (TEST has an immediate).
  function automatic logic [3:0] imm_size(input logic [7:0] op, input logic e, input logic o16,
                                          input logic w, input logic [2:0] reg_f);
    logic [3:0] z;
    z = o16 ? 4'd2 : 4'd4;
    imm_size = 4'd0;
    if (e) begin
      if (op[7:4] == 4'h8) imm_size = 4'd4;
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'd4) begin
      imm_size = 4'd1;
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'd5) begin
      imm_size = z;
    end else begin
      case (op) inside
        8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h83, 8'hA8, [8'hB0:8'hB7],
        8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'hD4, 8'hD5, [8'hE0:8'hE7], 8'hEB: imm_size = 4'd1;
        8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9:               imm_size = z;
        [8'hB8:8'hBF]:  imm_size = w ? 4'd8 : z;
        8'hC2, 8'hCA:   imm_size = 4'd2;
        8'hC8:          imm_size = 4'd3;
        [8'hA0:8'hA3]:  imm_size = 4'd8;
        8'hF6:          imm_size = (reg_f == 3'd0) ? 4'd1 : 4'd0;
        8'hF7:          imm_size = (reg_f == 3'd0) ? z : 4'd0;
        default:        imm_size = 4'd0;
      endcase
    end
  endfunction

  // First non-empty step among disp, imm; otherwise the instruction is complete.
  function automatic state_t next_step(input logic [2:0] d, input logic [3:0] i);
    if (d != 3'd0)      next_step = DISP;
    else if (i != 4'd0) next_step = IMM;
    else                next_step = DONE;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PFX;
      count     <= '0;
      rex       <= '0;
      opsize16  <= 1'b0;
      esc       <= 1'b0;
      opcode    <= '0;
      has_modrm <= 1'b0;
      modrm     <= '0;
      err       <= 1'b0;
      disp_left <= '0;
      imm_left  <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      rex       <= rex_n;
      opsize16  <= opsize16_n;
      esc       <= esc_n;
      opcode    <= opcode_n;
      has_modrm <= has_modrm_n;
      modrm     <= modrm_n;
      err       <= err_n;
      disp_left <= disp_left_n;
      imm_left  <= imm_left_n;
    end
  end

  assign done     = (state == DONE);
  assign in_ready = !done && !flush;

  always_comb begin
    state_n     = state;
    count_n     = count;
    rex_n       = rex;
    opsize16_n  = opsize16;
    esc_n       = esc;
    opcode_n    = opcode;
    has_modrm_n = has_modrm;
    modrm_n     = modrm;
    err_n       = err;
    disp_left_n = disp_left;
    imm_left_n  = imm_left;
    hm          = 1'b0;
    imm_sz      = '0;
    disp_sz     = '0;

    if (flush || (done && out_ready)) begin
      state_n     = PFX;
      count_n     = '0;
      rex_n       = '0;
      opsize16_n  = 1'b0;
      esc_n       = 1'b0;
      opcode_n    = '0;
      has_modrm_n = 1'b0;
      modrm_n     = '0;
      err_n       = 1'b0;
      disp_left_n = '0;
      imm_left_n  = '0;
    end else if (!done && in_valid) begin
      count_n = count + 4'd1;
      case (state)
        PFX: begin
          if (in_byte inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67,
                              8'hF0, 8'hF2, 8'hF3}) begin
            // A REX followed by a legacy prefix is not adjacent to the opcode, so it is dropped.
            rex_n = '0;
            if (in_byte == 8'h66) opsize16_n = 1'b1;
          end else if (in_byte[7:4] == 4'h4) begin
            rex_n = in_byte[3:0];
          end else if (in_byte == 8'h0F) begin
            esc_n   = 1'b1;
            state_n = ESC2;
          end else begin
            opcode_n    = in_byte;
            hm          = modrm_tbl[8'd255 - in_byte];
            imm_sz      = imm_size(in_byte, 1'b0, opsize16, rex[3], 3'd0);
            has_modrm_n = hm;
            imm_left_n  = imm_sz;
            state_n     = hm ? MODRM : next_step(3'd0, imm_sz);
          end
        end
        ESC2: begin
          opcode_n    = in_byte;
          hm          = !(in_byte[7:4] == 4'h8 || in_byte inside {8'h05, 8'h31, 8'hA2});
          imm_sz      = imm_size(in_byte, 1'b1, opsize16, rex[3], 3'd0);
          has_modrm_n = hm;
          imm_left_n  = imm_sz;
          state_n     = hm ? MODRM : next_step(3'd0, imm_sz);
        end
        MODRM: begin
          modrm_n    = in_byte;
          // Immediate is resized here because F6/F7 depend on ModRM.reg.
          imm_sz     = imm_size(opcode, esc, opsize16, rex[3], in_byte[5:3]);
          imm_left_n = imm_sz;
          case (in_byte[7:6])
            2'b01:   disp_sz = 3'd1;
            2'b10:   disp_sz = 3'd4;
            2'b00:   disp_sz = (in_byte[2:0] == 3'd5) ? 3'd4 : 3'd0;
            default: disp_sz = 3'd0;
          endcase
          disp_left_n = disp_sz;
          if (in_byte[7:6] != 2'b11 && in_byte[2:0] == 3'd4) state_n = SIB;
          else                                                state_n = next_step(disp_sz, imm_sz);
        end
        SIB: begin
          disp_sz = disp_left;
          if (modrm[7:6] == 2'b00 && in_byte[2:0] == 3'd5) disp_sz = 3'd4;
          disp_left_n = disp_sz;
          state_n     = next_step(disp_sz, imm_left);
        end
        DISP: begin
          disp_left_n = disp_left - 3'd1;
          state_n     = (disp_left == 3'd1) ? next_step(3'd0, imm_left) : DISP;
        end
        IMM: begin
          imm_left_n = imm_left - 4'd1;
          state_n    = (imm_left == 4'd1) ? DONE : IMM;
        end
        default: state_n = state;
      endcase
      // Length limit hit with bytes still outstanding: close the instruction as an error.
      if (state_n != DONE && count_n == 4'(MAX_LEN)) begin
        state_n = DONE;
        err_n   = 1'b1;
      end
    end
  end

  assign out_valid     = done;
  assign out_len       = done ? count     : 4'd0;
  assign out_opcode    = done ? opcode    : 8'd0;
  assign out_esc       = done && esc;
  assign out_rex       = done ? rex       : 4'd0;
  assign out_opsize16  = done && opsize16;
  assign out_has_modrm = done && has_modrm;
  assign out_modrm     = done ? modrm     : 8'd0;
  assign out_err       = done && err;

endmodule

// File: tb/tb_decode_len_sequencer.sv
// Randomized and directed bench for decode_len_sequencer with a whole-instruction reference parser and scoreboard.
module tb_decode_len_sequencer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] len;
    logic       err;
    logic [7:0] op;
    logic       esc;
    logic [3:0] rex;
    logic       o16;
    logic       hm;
    logic [7:0] modrm;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         flush = 1'b0;
  logic [255:0] modrm_tbl;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_byte = 8'd0;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_len;
  logic [7:0]   out_opcode;
  logic         out_esc;
  logic [3:0]   out_rex;
  logic         out_opsize16;
  logic         out_has_modrm;
  logic [7:0]   out_modrm;
  logic         out_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hold = 1'b0;
  exp_t exp_q[$];
  logic [7:0] pfx_list [7] = '{8'h66, 8'hF2, 8'hF3, 8'h2E, 8'h67, 8'hF0, 8'h64};

  decode_len_sequencer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .modrm_tbl(modrm_tbl),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_len(out_len),
    .out_opcode(out_opcode), .out_esc(out_esc), .out_rex(out_rex),
    .out_opsize16(out_opsize16), .out_has_modrm(out_has_modrm),
    .out_modrm(out_modrm), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] at(bq_t s, int i);
    return (i < s.size()) ? s[i] : 8'h00;
  endfunction

  function automatic bit is_legacy(logic [7:0] b);
    return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};
  endfunction

  // One-byte-map immediate sizes straight from the opcode table.
  function automatic int ref_imm(logic [7:0] op, logic o16, logic w, logic [2:0] r);
    int z = o16 ? 2 : 4;
    if (op < 8'h40 && (op % 8) == 4) return 1;
    if (op < 8'h40 && (op % 8) == 5) return z;
    if (op inside {8'h6A, 8'h6B, 8'h80, 8'h83, 8'hA8, 8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'hD4, 8'hD5, 8'hEB}) return 1;
    if (op >= 8'h70 && op <= 8'h7F) return 1;
    if (op >= 8'hB0 && op <= 8'hB7) return 1;
    if (op >= 8'hE0 && op <= 8'hE7) return 1;
    if (op inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9}) return z;
    if (op >= 8'hB8 && op <= 8'hBF) return w ? 8 : z;
    if (op == 8'hC2 || op == 8'hCA) return 2;
    if (op == 8'hC8) return 3;
    if (op >= 8'hA0 && op <= 8'hA3) return 8;
    if (op == 8'hF6 && r == 3'd0) return 1;
    if (op == 8'hF7 && r == 3'd0) return z;
    return 0;
  endfunction

  // Parse a whole instruction from the front of s and report its descriptor.
  function automatic exp_t ref_decode(bq_t s);
    exp_t e;
    int i = 0, disp = 0, imm = 0, full;
    logic [7:0] b, m, sib;
    bit more = 1'b1, has_sib = 1'b0;
    e = '0;
    b = 8'h00;
    sib = 8'h00;
    while (more) begin
      b = at(s, i); i++;
      if (is_legacy(b)) begin e.rex = 4'd0; if (b == 8'h66) e.o16 = 1'b1; end
      else if (b >= 8'h40 && b <= 8'h4F) e.rex = b[3:0];
      else more = 1'b0;
    end
    if (b == 8'h0F) begin
      e.esc = 1'b1;
      b = at(s, i); i++;
      e.op = b;
      e.hm = !((b >= 8'h80 && b <= 8'h8F) || b == 8'h05 || b == 8'h31 || b == 8'hA2);
      imm = (b >= 8'h80 && b <= 8'h8F) ? 4 : 0;
    end else begin
      e.op = b;
      e.hm = modrm_tbl[255 - int'(b)];
    end
    if (e.hm) begin
      m = at(s, i); i++;
      e.modrm = m;
      if (m[7:6] != 2'd3 && m[2:0] == 3'd4) begin sib = at(s, i); i++; has_sib = 1'b1; end
      if (m[7:6] == 2'd1) disp = 1;
      else if (m[7:6] == 2'd2) disp = 4;
      else if (m[7:6] == 2'd0) disp = ((has_sib ? sib[2:0] : m[2:0]) == 3'd5) ? 4 : 0;
    end
    if (!e.esc) imm = ref_imm(e.op, e.o16, e.rex[3], e.modrm[5:3]);
    full = i + disp + imm;
    if (full > 15) begin e.err = 1'b1; e.len = 8'd15; end
    else e.len = 8'(full);
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Queue the expected descriptor, then send only the bytes the DUT will consume.
  task automatic send_instr(input bq_t q);
    exp_t e = ref_decode(q);
    exp_q.push_back(e);
    for (int k = 0; k < int'(e.len); k++) send_byte(q[k]);
  endtask

  task automatic gen_random(output bq_t q);
    exp_t e;
    logic [7:0] b;
    do begin
      q = {};
      repeat ($urandom_range(0, 2)) q.push_back(pfx_list[$urandom_range(0, 6)]);
      if ($urandom_range(0, 1) == 1) q.push_back(8'h40 | 8'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        q.push_back(8'h0F);
        b = 8'($urandom_range(0, 255));
      end else begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h0F || (b >= 8'h40 && b <= 8'h4F) || is_legacy(b));
      end
      q.push_back(b);
      repeat (14) q.push_back(8'($urandom_range(0, 255)));
      e = ref_decode(q);
    end while (e.err);
    while (q.size() > int'(e.len)) void'(q.pop_back());
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each handshake, checks stability and in_ready while stalled.
  initial begin
    exp_t e;
    logic [27:0] snap, cur;
    bit have_prev = 1'b0;
    forever begin
      @(negedge clk);
      cur = {out_len, out_opcode, out_esc, out_rex, out_opsize16, out_has_modrm, out_modrm, out_err};
      if (reset_n && out_valid) begin
        if (have_prev) chk("stall_stable", {4'd0, cur}, {4'd0, snap});
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (out_ready && !flush) begin
          have_prev = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_descriptor", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("len", {28'd0, out_len}, {24'd0, e.len});
            chk("err", {31'd0, out_err}, {31'd0, e.err});
            if (!e.err) begin
              chk("opcode", {24'd0, out_opcode}, {24'd0, e.op});
              chk("esc", {31'd0, out_esc}, {31'd0, e.esc});
              chk("rex", {28'd0, out_rex}, {28'd0, e.rex});
              chk("opsize16", {31'd0, out_opsize16}, {31'd0, e.o16});
              chk("has_modrm", {31'd0, out_has_modrm}, {31'd0, e.hm});
              chk("modrm", {24'd0, out_modrm}, {24'd0, e.modrm});
            end
          end
        end else begin
          snap = cur;
          have_prev = 1'b1;
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    for (int op = 0; op < 256; op++) begin
      logic [7:0] o;
      o = 8'(op);
      modrm_tbl[255 - op] = (o < 8'h40 && o[2] == 1'b0) ||
                            (o inside {8'h62, 8'h63, 8'h69, 8'h6B, 8'hC0, 8'hC1, 8'hC4, 8'hC5,
                                       8'hC6, 8'hC7, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hF6, 8'hF7,
                                       8'hFE, 8'hFF}) ||
                            (o >= 8'h80 && o <= 8'h8F) || (o >= 8'hD8 && o <= 8'hDF);
    end
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_len", {28'd0, out_len}, 32'd0);
    chk("reset_out_rex", {28'd0, out_rex}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    q = {8'h48, 8'h89, 8'hE5};               send_instr(q);
    q = {8'h8B, 8'h44, 8'h24, 8'h08};        send_instr(q);
    q = {8'hC7, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}; send_instr(q);
    q = {8'h66, 8'hB8, 8'h34, 8'h12};        send_instr(q);
    q = {8'h48, 8'hB8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}; send_instr(q);
    q = {8'h0F, 8'h84, 8'h10, 8'h20, 8'h30, 8'h40}; send_instr(q);
    q = {};
    repeat (15) q.push_back(8'h66);
    q.push_back(8'h90);
    send_instr(q);                            // limit reached: 15 bytes consumed, err
    q = {8'h90};                             send_instr(q);
    q = {8'h48, 8'h66, 8'h90};               send_instr(q);
    q = {8'hF7, 8'hC0, 8'h01, 8'h00, 8'h00, 8'h00}; send_instr(q);
    q = {8'hF6, 8'hD0};                      send_instr(q);
    wait_drain();

    // Descriptor held by out_ready low for 5 cycles.
    hold = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    q = {8'h90};
    send_instr(q);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    hold = 1'b0;
    wait_drain();

    // Flush mid-instruction: no descriptor, offered byte not consumed.
    send_byte(8'h8B);
    send_byte(8'h44);
    in_valid = 1'b1;
    in_byte  = 8'h24;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q = {8'hC3};
    send_instr(q);
    wait_drain();

    // Async reset while a descriptor is pending: it must vanish without a handshake.
    hold = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h90);
    @(negedge clk);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_reset_len", {28'd0, out_len}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    hold = 1'b0;
    q = {8'hC3};
    send_instr(q);

    for (int n = 0; n < 200; n++) begin
      gen_random(q);
      send_instr(q);
    end
    wait_drain();
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
